// File: rtl/uncache_unit_pkg.sv
// Shared constants for the uncached load/store engine: access types,
// FSM state encoding and default bus widths.
package uncache_unit_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned TYPE_W     = 3;

    localparam logic [TYPE_W-1:0] TYPE_BYTE = 3'b000;
    localparam logic [TYPE_W-1:0] TYPE_HALF = 3'b001;
    localparam logic [TYPE_W-1:0] TYPE_WORD = 3'b010;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_RD_REQ  = ST_RD_REQ,
        S_RD_WAIT = ST_RD_WAIT,
        S_WR_REQ  = ST_WR_REQ,
        S_RESP    = ST_RESP
    } state_e;

endpackage

// File: rtl/uncache_unit.sv
// Uncached load/store engine: latches one MEM request and runs exactly one
// single-beat bridge transaction for it, then pulses data_ok.
module uncache_unit
    import uncache_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              op,
    input  logic [2:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wstrb,
    input  logic [DATA_W-1:0] wdata,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_req,
    output logic [2:0]        rd_type,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [DATA_W-1:0] ret_data,
    output logic              wr_req,
    output logic [2:0]        wr_type,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_wstrb,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_rdy
);

    state_e              state_q, state_d;
    logic [TYPE_W-1:0]   size_q,  size_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                data_ok_q, data_ok_d;
    logic                rd_req_q,  rd_req_d;
    logic                wr_req_q,  wr_req_d;

    // Next state and request latch; outputs are decoded from the next state
    // so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    size_d  = size;
                    addr_d  = addr;
                    wstrb_d = wstrb;
                    wdata_d = wdata;
                    state_d = op ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (rd_rdy) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Non-final beats are dropped; only the last beat completes.
                if (ret_valid && ret_last) begin
                    rdata_d = ret_data;
                    state_d = S_RESP;
                end
            end
            S_WR_REQ: begin
                if (wr_rdy) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        data_ok_d = (state_d == S_RESP);
        rd_req_d  = (state_d == S_RD_REQ);
        wr_req_d  = (state_d == S_WR_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            size_q    <= '0;
            addr_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            data_ok_q <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            data_ok_q <= data_ok_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
        end
    end

    assign data_ok  = data_ok_q;
    assign rdata    = rdata_q;
    assign rd_req   = rd_req_q;
    assign rd_type  = size_q;
    assign rd_addr  = addr_q;
    assign wr_req   = wr_req_q;
    assign wr_type  = size_q;
    assign wr_addr  = addr_q;
    assign wr_wstrb = wstrb_q;
    assign wr_data  = wdata_q;

endmodule
